// File: rtl/fpu_vec_shuf_seq.sv
// fpu_vec_shuf_seq
// Sequences one shared 4:1 lane-select mux so it can build a whole shuffled
// 4-lane vector, one output lane per clock.
//
// Ports:
//   clock, reset_n        core clock, asynchronous active-low reset
//   reqValid/reqReady     request handshake (ready only while idle)
//   reqVec, reqShuf       source vector (lane k at [k*LANEW +: LANEW]) and
//                         2-bit-per-lane shuffle control
//   reqDoShuf             1 = apply reqShuf, 0 = identity
//   flush                 synchronous abort, highest priority
//   muxValA..D            captured source lanes 0..3 shown to the shared mux
//   muxIdxShuf/muxIdxDfl  shuffle / default index for the current lane
//   muxDoShuf             captured reqDoShuf (only driven while running)
//   muxOut                lane returned by the shared mux
//   respValid/respReady   response handshake
//   respVec               assembled result vector
//   busy                  high while running or holding a result
module fpu_vec_shuf_seq #(
  parameter int LANEW = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic [4*LANEW-1:0] reqVec,
  input  logic [7:0]         reqShuf,
  input  logic               reqDoShuf,
  input  logic               flush,
  output logic [LANEW-1:0]   muxValA,
  output logic [LANEW-1:0]   muxValB,
  output logic [LANEW-1:0]   muxValC,
  output logic [LANEW-1:0]   muxValD,
  output logic [1:0]         muxIdxShuf,
  output logic [1:0]         muxIdxDfl,
  output logic               muxDoShuf,
  input  logic [LANEW-1:0]   muxOut,
  output logic               respValid,
  input  logic               respReady,
  output logic [4*LANEW-1:0] respVec,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         lane;
  logic [4*LANEW-1:0] capVec;
  logic [7:0]         capShuf;
  logic               capDoShuf;
  logic [4*LANEW-1:0] respVecR;
  logic [1:0]         shufSel;

  // Pick the 2-bit shuffle field belonging to the lane being built.
  always_comb begin
    shufSel = 2'd0;
    case (lane)
      2'd0: shufSel = capShuf[1:0];
      2'd1: shufSel = capShuf[3:2];
      2'd2: shufSel = capShuf[5:4];
      2'd3: shufSel = capShuf[7:6];
      default: shufSel = 2'd0;
    endcase
  end

  // Main sequencer. Flush beats everything, so a request seen in the same
  // cycle as flush is never captured. The result register is cleared on
  // accept so a stale result can never leak into a new response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lane      <= 2'd0;
      capVec    <= '0;
      capShuf   <= 8'd0;
      capDoShuf <= 1'b0;
      respVecR  <= '0;
    end else if (flush) begin
      state    <= IDLE;
      lane     <= 2'd0;
      respVecR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            capVec    <= reqVec;
            capShuf   <= reqShuf;
            capDoShuf <= reqDoShuf;
            lane      <= 2'd0;
            respVecR  <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < 4; k++) begin
            if (lane == 2'(k)) begin
              respVecR[k*LANEW +: LANEW] <= muxOut;
            end
          end
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (respReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mux source lanes always reflect the captured vector; the index and
  // enable controls are only live while a vector is being built.
  assign muxValA    = capVec[0*LANEW +: LANEW];
  assign muxValB    = capVec[1*LANEW +: LANEW];
  assign muxValC    = capVec[2*LANEW +: LANEW];
  assign muxValD    = capVec[3*LANEW +: LANEW];
  assign muxIdxShuf = (state == RUN) ? shufSel : 2'd0;
  assign muxIdxDfl  = (state == RUN) ? lane : 2'd0;
  assign muxDoShuf  = (state == RUN) ? capDoShuf : 1'b0;

  assign reqReady  = (state == IDLE);
  assign respValid = (state == DONE);
  assign busy      = (state != IDLE);
  assign respVec   = respVecR;

endmodule

// File: tb/tb_fpu_vec_shuf_seq.sv
// Testbench for fpu_vec_shuf_seq. Models the external shared lane mux and
// checks results against a lane-permutation reference model.
module tb_fpu_vec_shuf_seq;

  localparam int LANEW = 32;

  logic               clock;
  logic               reset_n;
  logic               reqValid;
  logic               reqReady;
  logic [4*LANEW-1:0] reqVec;
  logic [7:0]         reqShuf;
  logic               reqDoShuf;
  logic               flush;
  logic [LANEW-1:0]   muxValA, muxValB, muxValC, muxValD;
  logic [1:0]         muxIdxShuf;
  logic [1:0]         muxIdxDfl;
  logic               muxDoShuf;
  logic [LANEW-1:0]   muxOut;
  logic               respValid;
  logic               respReady;
  logic [4*LANEW-1:0] respVec;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int acceptCycles[$];

  logic [4*LANEW-1:0] idVec;

  fpu_vec_shuf_seq #(.LANEW(LANEW)) dut (
    .clock(clock), .reset_n(reset_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqVec(reqVec), .reqShuf(reqShuf), .reqDoShuf(reqDoShuf),
    .flush(flush),
    .muxValA(muxValA), .muxValB(muxValB), .muxValC(muxValC), .muxValD(muxValD),
    .muxIdxShuf(muxIdxShuf), .muxIdxDfl(muxIdxDfl), .muxDoShuf(muxDoShuf),
    .muxOut(muxOut),
    .respValid(respValid), .respReady(respReady), .respVec(respVec),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External shared mux: doShuf chooses between shuffle and default index.
  always_comb begin
    logic [1:0] sel;
    muxOut = '0;
    sel = muxDoShuf ? muxIdxShuf : muxIdxDfl;
    case (sel)
      2'd0: muxOut = muxValA;
      2'd1: muxOut = muxValB;
      2'd2: muxOut = muxValC;
      2'd3: muxOut = muxValD;
      default: muxOut = '0;
    endcase
  end

  // Accept monitor: records the cycle number of every accepted request.
  always @(posedge clock) begin
    if (reset_n && reqValid && reqReady && !flush) acceptCycles.push_back(cycleCnt);
    cycleCnt <= cycleCnt + 1;
  end

  // Reference model: output lane k takes source lane shuf[2k+1:2k] (or k).
  function automatic logic [4*LANEW-1:0] shufModel(input logic [4*LANEW-1:0] v,
                                                   input logic [7:0] s, input logic d);
    logic [4*LANEW-1:0] r;
    int src;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      src = d ? int'((s >> (2*k)) & 8'h3) : k;
      r[k*LANEW +: LANEW] = v[src*LANEW +: LANEW];
    end
    return r;
  endfunction

  // Present a request at a negedge, wait for it to be accepted, then drop
  // reqValid and scramble the request inputs. Returns on the negedge after
  // the accept edge.
  task automatic sendReq(input logic [4*LANEW-1:0] v, input logic [7:0] s,
                         input logic d, output bit ok);
    ok = 1'b0;
    reqVec = v; reqShuf = s; reqDoShuf = d; reqValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (reqReady && !flush) begin
        @(posedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    reqValid = 1'b0;
    reqVec = {$urandom(), $urandom(), $urandom(), $urandom()};
    reqShuf = 8'($urandom());
    reqDoShuf = ~d;
  endtask

  task automatic waitResp(output int cyc);
    cyc = 0;
    while (!respValid && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    checks++;
    if ({respValid, busy, muxDoShuf, muxIdxShuf, muxIdxDfl} !== 7'd0 || respVec !== '0
        || muxValA !== '0 || muxValD !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: respValid=%0b busy=%0b respVec=%h muxValA=%h required all 0",
               respValid, busy, respVec, muxValA);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (reqReady !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: reqReady=%0b busy=%0b required 1/0", reqReady, busy);
    end
  endtask

  task automatic test_identity;
    bit ok;
    int c;
    respReady = 1'b1;
    sendReq(idVec, 8'hFF, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("[TB] FAIL id_accept: not accepted"); end
    waitResp(c);
    checks++;
    if (c != 4) begin errors++; $display("[TB] FAIL id_latency: %0d cycles required 4", c); end
    checks++;
    if (respVec !== idVec) begin
      errors++;
      $display("[TB] FAIL id_data: got %h required %h", respVec, idVec);
    end
    @(negedge clock);
    checks++;
    if (respValid !== 1'b0 || reqReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL id_release: respValid=%0b reqReady=%0b required 0/1", respValid, reqReady);
    end
  endtask

  task automatic test_reverse;
    bit ok;
    logic [1:0] revIdx [4];
    logic [4*LANEW-1:0] expV;
    revIdx = '{2'd3, 2'd2, 2'd1, 2'd0};
    expV = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    respReady = 1'b1;
    sendReq(idVec, 8'h1B, 1'b1, ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (muxIdxShuf !== revIdx[k] || muxIdxDfl !== 2'(k) || muxDoShuf !== 1'b1
          || busy !== 1'b1 || muxValA !== 32'h11111111) begin
        errors++;
        $display("[TB] FAIL rev_mux_lane%0d: idxShuf=%0d idxDfl=%0d doShuf=%0b valA=%h required %0d/%0d/1/11111111",
                 k, muxIdxShuf, muxIdxDfl, muxDoShuf, muxValA, revIdx[k], k);
      end
      @(negedge clock);
    end
    checks++;
    if (respValid !== 1'b1 || respVec !== expV) begin
      errors++;
      $display("[TB] FAIL rev_data: valid=%0b got %h required %h", respValid, respVec, expV);
    end
    checks++;
    if (muxIdxShuf !== 2'd0 || muxIdxDfl !== 2'd0 || muxDoShuf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rev_idle_mux: idxShuf=%0d idxDfl=%0d doShuf=%0b required 0", muxIdxShuf, muxIdxDfl, muxDoShuf);
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure;
    bit ok;
    int c;
    respReady = 1'b0;
    sendReq(idVec, 8'hAA, 1'b1, ok);
    waitResp(c);
    checks++;
    if (c != 4) begin errors++; $display("[TB] FAIL bp_latency: %0d cycles required 4", c); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (respValid !== 1'b1 || reqReady !== 1'b0 || respVec !== {4{32'h33333333}}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid=%0b ready=%0b got %h required 1/0/all 33333333",
                 i, respValid, reqReady, respVec);
      end
      @(negedge clock);
    end
    respReady = 1'b1;
    @(negedge clock);
    checks++;
    if (respValid !== 1'b0 || reqReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: valid=%0b ready=%0b required 0/1", respValid, reqReady);
    end
  endtask

  task automatic test_flush;
    bit ok;
    bit sawValid;
    int c;
    respReady = 1'b1;
    reqVec = idVec; reqShuf = 8'h00; reqDoShuf = 1'b0;
    reqValid = 1'b1; flush = 1'b1;
    @(negedge clock);
    reqValid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_accept: busy=%0b required 0", busy); end
    sendReq(idVec, 8'h1B, 1'b1, ok);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (muxIdxDfl !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_setup: lane=%0d busy=%0b required 2/1", muxIdxDfl, busy);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || reqReady !== 1'b1 || respValid !== 1'b0 || respVec !== '0) begin
      errors++;
      $display("[TB] FAIL flush_abort: busy=%0b ready=%0b valid=%0b vec=%h required 0/1/0/0",
               busy, reqReady, respValid, respVec);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sawValid |= respValid;
      @(negedge clock);
    end
    checks++;
    if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_resp: respValid seen=1 required 0"); end
    sendReq(idVec, 8'h00, 1'b0, ok);
    waitResp(c);
    checks++;
    if (c != 4 || respVec !== idVec) begin
      errors++;
      $display("[TB] FAIL flush_recover: cycles=%0d got %h required 4 / %h", c, respVec, idVec);
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset;
    bit ok;
    int c;
    respReady = 1'b0;
    sendReq(idVec, 8'h1B, 1'b1, ok);
    waitResp(c);
    checks++;
    if (respValid !== 1'b1) begin errors++; $display("[TB] FAIL ares_setup: respValid=%0b required 1", respValid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (respValid !== 1'b0 || busy !== 1'b0 || respVec !== '0 || muxValA !== '0) begin
      errors++;
      $display("[TB] FAIL ares_immediate: valid=%0b busy=%0b vec=%h valA=%h required 0",
               respValid, busy, respVec, muxValA);
    end
    #1;
    reset_n = 1'b1;
    respReady = 1'b1;
    @(negedge clock);
    checks++;
    if (reqReady !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ares_release: ready=%0b busy=%0b required 1/0", reqReady, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [4*LANEW-1:0] vA, vB;
    logic [7:0] sA, sB;
    int n;
    vA = {$urandom(), $urandom(), $urandom(), $urandom()};
    vB = {$urandom(), $urandom(), $urandom(), $urandom()};
    sA = 8'h39;
    sB = 8'hC6;
    acceptCycles.delete();
    respReady = 1'b1;
    reqVec = vA; reqShuf = sA; reqDoShuf = 1'b1; reqValid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (acceptCycles.size() < 1 && n < 20);
    reqVec = vB; reqShuf = sB;
    n = 0;
    while (!respValid && n < 40) begin @(negedge clock); n++; end
    checks++;
    if (respValid !== 1'b1 || respVec !== shufModel(vA, sA, 1'b1)) begin
      errors++;
      $display("[TB] FAIL b2b_first: valid=%0b got %h required %h", respValid, respVec, shufModel(vA, sA, 1'b1));
    end
    n = 0;
    while (acceptCycles.size() < 2 && n < 40) begin @(negedge clock); n++; end
    reqValid = 1'b0;
    checks++;
    if (acceptCycles.size() != 2 || acceptCycles[1] - acceptCycles[0] != 6) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: accepts=%0d spacing=%0d required 2/6", acceptCycles.size(),
               (acceptCycles.size() >= 2) ? acceptCycles[1] - acceptCycles[0] : -1);
    end
    n = 0;
    while (!respValid && n < 40) begin @(negedge clock); n++; end
    checks++;
    if (respValid !== 1'b1 || respVec !== shufModel(vB, sB, 1'b1)) begin
      errors++;
      $display("[TB] FAIL b2b_second: valid=%0b got %h required %h", respValid, respVec, shufModel(vB, sB, 1'b1));
    end
    @(negedge clock);
  endtask

  task automatic test_random;
    bit ok;
    int c;
    logic [4*LANEW-1:0] v;
    logic [7:0] s;
    logic d;
    respReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      s = 8'($urandom());
      d = 1'($urandom_range(0, 1));
      sendReq(v, s, d, ok);
      waitResp(c);
      checks++;
      if (!ok || c != 4 || respVec !== shufModel(v, s, d)) begin
        errors++;
        $display("[TB] FAIL rand%0d: shuf=%h do=%0b cycles=%0d got %h required %h",
                 i, s, d, c, respVec, shufModel(v, s, d));
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idVec = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    reqValid = 1'b0; reqVec = '0; reqShuf = 8'd0; reqDoShuf = 1'b0;
    flush = 1'b0; respReady = 1'b1;
    test_reset;
    test_identity;
    test_reverse;
    test_backpressure;
    test_flush;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
